// File: rtl/crtc_loader_pkg.sv
// crtc_loader_pkg: shared types and constants for the CRTC mode loader.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: FSM state enum, register-file geometry, the four built-in mode
// tables (R0..R15) and the per-register read-back masks of the 6845.
package crtc_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IDX,
    S_DAT,
    S_RD,
    S_WAIT,
    S_FIN
  } state_t;

  localparam int NUM_REGS       = 16;
  localparam int LOCK_FIRST_REG = 10;
  localparam int CURSOR_HI_REG  = 14;

  // R12..R15 (start address, cursor address) load as zero for every mode.
  localparam logic [7:0] MODE_TABLE [4][NUM_REGS] = '{
    '{8'd97,  8'd80, 8'd82, 8'd15, 8'd25,  8'd6, 8'd25,  8'd25,
      8'd0,   8'd13, 8'd11, 8'd12, 8'd0,   8'd0, 8'd0,   8'd0},
    '{8'd113, 8'd80, 8'd90, 8'd10, 8'd31,  8'd6, 8'd25,  8'd28,
      8'd2,   8'd7,  8'd6,  8'd7,  8'd0,   8'd0, 8'd0,   8'd0},
    '{8'd56,  8'd40, 8'd45, 8'd10, 8'd31,  8'd6, 8'd25,  8'd28,
      8'd2,   8'd7,  8'd6,  8'd7,  8'd0,   8'd0, 8'd0,   8'd0},
    '{8'd56,  8'd40, 8'd45, 8'd10, 8'd127, 8'd6, 8'd100, 8'd112,
      8'd2,   8'd1,  8'd6,  8'd7,  8'd0,   8'd0, 8'd0,   8'd0}
  };

  // Bits the CRTC actually implements per register; R8 reads back as zero.
  localparam logic [7:0] REG_MASK [NUM_REGS] = '{
    8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h7F, 8'h1F, 8'h7F, 8'h7F,
    8'h00, 8'h1F, 8'h7F, 8'h1F, 8'h3F, 8'hFF, 8'h3F, 8'hFF
  };

endpackage

// File: rtl/crtc_mode_rom.sv
// crtc_mode_rom: mode-table and read-back-mask lookup.
// Latency: combinational.
// Backpressure: none.
// Ports: mode (table select), reg_idx (register number) -> value, mask.
import crtc_loader_pkg::*;

module crtc_mode_rom (
  input  logic [1:0] mode,
  input  logic [3:0] reg_idx,
  output logic [7:0] value,
  output logic [7:0] mask
);

  assign value = MODE_TABLE[mode][reg_idx];
  assign mask  = REG_MASK[reg_idx];

endmodule

// File: rtl/crtc_mode_loader.sv
// crtc_mode_loader: programs a 6845 CRTC over its index/data port with a mode table or cursor position.
// Latency: first stroke one cycle after acceptance; per register IDX+DAT (+RD) strokes, each followed by GAP idles.
// Backpressure: start is dropped while busy; cur_req is a held level, deferred behind a load, released by cur_ack.
// Build option: define CRTC_LOADER_VERIFY_EN to add a masked read-back after every data stroke (error/error_reg).
// Ports: clk/reset_n (sync, active low); start/mode_sel/lock request a table load; cur_req/cur_pos/cur_ack
//        cursor update handshake; busy/done status; crtc_cs/a0/write/read/bus/bus_in CRTC port; error/error_reg.
import crtc_loader_pkg::*;

module crtc_mode_loader #(
  parameter int         GAP          = 0,
  parameter logic [1:0] DEFAULT_MODE = 2'd0,
  parameter bit         AUTOLOAD     = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  mode_sel,
  input  logic        lock,
  input  logic        cur_req,
  input  logic [13:0] cur_pos,
  output logic        cur_ack,
  output logic        busy,
  output logic        done,
  output logic        crtc_cs,
  output logic        crtc_a0,
  output logic        crtc_write,
  output logic        crtc_read,
  output logic [7:0]  crtc_bus,
  input  logic [7:0]  crtc_bus_in,
  output logic        error,
  output logic [4:0]  error_reg
);

  localparam int         GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [3:0] LAST_REG = 4'(NUM_REGS - 1);

  state_t        state_q, state_d, ret_q, ret_d, after;
  logic [3:0]    ptr_q, ptr_d;
  logic [1:0]    mode_q, mode_d;
  logic          cursor_q, cursor_d;
  logic [13:0]   curpos_q, curpos_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          auto_q, auto_d;
  logic          accept_start, accept_cur, stroke, reg_end;
  logic [7:0]    rom_value, rom_mask, dat_val, bus_d;
  logic          cs_d, a0_d, wr_d;

  crtc_mode_rom u_rom (
    .mode    (mode_d),
    .reg_idx (ptr_d),
    .value   (rom_value),
    .mask    (rom_mask)
  );

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    ptr_d        = ptr_q;
    mode_d       = mode_q;
    cursor_d     = cursor_q;
    curpos_d     = curpos_q;
    gap_d        = gap_q;
    auto_d       = auto_q;
    accept_start = 1'b0;
    accept_cur   = 1'b0;
    stroke       = 1'b0;
    reg_end      = 1'b0;
    after        = S_FIN;
    case (state_q)
      S_IDLE: begin
        // auto_q is set only for the first cycle out of reset and acts as a start.
        if (start || auto_q) begin
          accept_start = 1'b1;
          auto_d       = 1'b0;
          mode_d       = auto_q ? DEFAULT_MODE : mode_sel;
          ptr_d        = lock ? 4'(LOCK_FIRST_REG) : 4'd0;
          cursor_d     = 1'b0;
          state_d      = S_IDX;
        end else if (cur_req) begin
          accept_cur = 1'b1;
          ptr_d      = 4'(CURSOR_HI_REG);
          cursor_d   = 1'b1;
          curpos_d   = cur_pos;
          state_d    = S_IDX;
        end
      end
      S_IDX: begin
        stroke = 1'b1;
        after  = S_DAT;
      end
`ifdef CRTC_LOADER_VERIFY_EN
      S_DAT: begin
        stroke = 1'b1;
        after  = S_RD;
      end
      S_RD: begin
        stroke  = 1'b1;
        reg_end = 1'b1;
      end
`else
      S_DAT: begin
        stroke  = 1'b1;
        reg_end = 1'b1;
      end
`endif
      S_WAIT: begin
        if (gap_q == '0) state_d = ret_q;
        else             gap_d   = gap_q - GW'(1);
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The pointer advances as the last stroke of a register completes, so a
    // following WAIT already holds the next register number.
    if (reg_end) begin
      if (ptr_q == LAST_REG) begin
        after = S_FIN;
      end else begin
        after = S_IDX;
        ptr_d = ptr_q + 4'd1;
      end
    end

    if (stroke) begin
      if (GAP > 0) begin
        state_d = S_WAIT;
        ret_d   = after;
        gap_d   = GW'(GAP - 1);
      end else begin
        state_d = after;
      end
    end
  end

  // Outputs are decoded from the next state and registered, so strobes line up
  // exactly with the state the FSM occupies.
  assign dat_val = cursor_d ? ((ptr_d == 4'(CURSOR_HI_REG)) ? {2'b00, curpos_d[13:8]} : curpos_d[7:0])
                            : rom_value;

  always_comb begin
    cs_d  = 1'b0;
    a0_d  = 1'b0;
    wr_d  = 1'b0;
    bus_d = 8'h00;
    case (state_d)
      S_IDX: begin
        cs_d  = 1'b1;
        wr_d  = 1'b1;
        bus_d = {4'b0000, ptr_d};
      end
      S_DAT: begin
        cs_d  = 1'b1;
        a0_d  = 1'b1;
        wr_d  = 1'b1;
        bus_d = dat_val;
      end
`ifdef CRTC_LOADER_VERIFY_EN
      S_RD: begin
        cs_d = 1'b1;
        a0_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      ptr_q      <= 4'd0;
      mode_q     <= 2'd0;
      cursor_q   <= 1'b0;
      curpos_q   <= 14'd0;
      gap_q      <= '0;
      auto_q     <= AUTOLOAD;
      crtc_cs    <= 1'b0;
      crtc_a0    <= 1'b0;
      crtc_write <= 1'b0;
      crtc_bus   <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      cur_ack    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      ptr_q      <= ptr_d;
      mode_q     <= mode_d;
      cursor_q   <= cursor_d;
      curpos_q   <= curpos_d;
      gap_q      <= gap_d;
      auto_q     <= auto_d;
      crtc_cs    <= cs_d;
      crtc_a0    <= a0_d;
      crtc_write <= wr_d;
      crtc_bus   <= bus_d;
      busy       <= (state_d == S_IDX) || (state_d == S_DAT) || (state_d == S_RD) || (state_d == S_WAIT);
      done       <= (state_d == S_FIN);
      cur_ack    <= accept_cur;
    end
  end

`ifdef CRTC_LOADER_VERIFY_EN
  logic       rd_q, error_q;
  logic [4:0] error_reg_q;
  logic [7:0] exp_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_q        <= 1'b0;
      error_q     <= 1'b0;
      error_reg_q <= 5'd0;
      exp_q       <= 8'h00;
    end else begin
      rd_q <= (state_d == S_RD);
      if (state_d == S_DAT) exp_q <= dat_val & rom_mask;
      // Only the first mismatch is recorded; the sequence carries on regardless.
      if (accept_start) begin
        error_q     <= 1'b0;
        error_reg_q <= 5'd0;
      end else if (state_q == S_RD && crtc_bus_in != exp_q && !error_q) begin
        error_q     <= 1'b1;
        error_reg_q <= {1'b0, ptr_q};
      end
    end
  end

  assign crtc_read = rd_q;
  assign error     = error_q;
  assign error_reg = error_reg_q;
`else
  logic unused_readback;
  assign unused_readback = ^{crtc_bus_in, rom_mask};
  assign crtc_read = 1'b0;
  assign error     = 1'b0;
  assign error_reg = 5'd0;
`endif

endmodule
